// File: rtl/cla_pkg.sv
// Shared constants and configuration helpers for the pipelined carry-lookahead adder.
// Imported by the group cell and the pipelined top.
package cla_pkg;

    localparam int CLA_WIDTH = 32'sd16;
    localparam int CLA_GROUP = 32'sd4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Number of lookahead groups; returns 0 for an illegal WIDTH/GROUP pairing so the top can refuse it.
    function automatic int cla_num_groups(input int width, input int group);
        if ((group > 32'sd0) && (width >= group) && ((width % group) == 32'sd0)) begin
            return width / group;
        end else begin
            return 32'sd0;
        end
    endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit first-level lookahead cell: flat sum-of-products carries, sum, and group generate/propagate.
// Purely combinational.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic [GROUP-1:0] c,
    output logic             gg,
    output logic             gp
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;

    assign w_g = a & b;
    assign w_p = a ^ b;
    assign gp  = &w_p;

    // c[i] is the carry out of bit i, each term expanded directly from g/p/ci.
    always_comb begin
        logic w_term;
        c  = '0;
        gg = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            w_term = ci;
            for (int k = 0; k <= i; k++) begin
                w_term = w_term & w_p[k];
            end
            c[i] = w_term;
            for (int j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                c[i] = c[i] | w_term;
            end
        end
        for (int j = 0; j < GROUP; j++) begin
            w_term = w_g[j];
            for (int k = j + 1; k < GROUP; k++) begin
                w_term = w_term & w_p[k];
            end
            gg = gg | w_term;
        end
    end

    // Sum bits: propagate XOR carry into each bit.
    always_comb begin
        s[0] = w_p[0] ^ ci;
        for (int i = 1; i < GROUP; i++) begin
            s[i] = w_p[i] ^ c[i-1];
        end
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 forms group G/P, stage 2 resolves group carries and registers sum and flags.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = cla_num_groups(WIDTH, GROUP);

    if (NG == 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    logic [WIDTH-1:0] w_b;
    logic             w_c0;
    logic [WIDTH-1:0] w_s1_s;
    logic [WIDTH-1:0] w_s1_c;
    logic [NG-1:0]    w_s1_gg;
    logic [NG-1:0]    w_s1_gp;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_b;
    logic             r_c0;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic [NG-1:0]    r_gg;
    logic [NG-1:0]    r_gp;

    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_s2_s;
    logic [WIDTH-1:0] w_s2_c;
    logic [NG-1:0]    w_s2_gg;
    logic [NG-1:0]    w_s2_gp;
    logic [WIDTH-1:0] w_cin_bit;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_zero;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_s2_load;
    logic             w_unused;

    assign w_b  = (sub == MODE_SUB) ? ~y : y;
    assign w_c0 = (sub == MODE_SUB) ? 1'b1 : cin;

    assign w_s2_load = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;

    for (genvar gk = 0; gk < NG; gk++) begin : g_grp
        // Stage 1 cell sees a zero group carry-in; only its G/P are carried forward.
        cla_group #(.GROUP(GROUP)) u_s1 (
            .a  (x[gk*GROUP +: GROUP]),
            .b  (w_b[gk*GROUP +: GROUP]),
            .ci (1'b0),
            .s  (w_s1_s[gk*GROUP +: GROUP]),
            .c  (w_s1_c[gk*GROUP +: GROUP]),
            .gg (w_s1_gg[gk]),
            .gp (w_s1_gp[gk])
        );

        cla_group #(.GROUP(GROUP)) u_s2 (
            .a  (r_x[gk*GROUP +: GROUP]),
            .b  (r_b[gk*GROUP +: GROUP]),
            .ci (w_gc[gk]),
            .s  (w_s2_s[gk*GROUP +: GROUP]),
            .c  (w_s2_c[gk*GROUP +: GROUP]),
            .gg (w_s2_gg[gk]),
            .gp (w_s2_gp[gk])
        );

        assign w_cin_bit[gk*GROUP] = w_gc[gk];
        for (genvar gi = 1; gi < GROUP; gi++) begin : g_bit
            assign w_cin_bit[gk*GROUP+gi] = w_s2_c[gk*GROUP+gi-1];
        end
    end

    // Second-level lookahead: every group carry is a flat OR of G/P products, no chain.
    always_comb begin
        logic w_term;
        w_gc    = '0;
        w_gc[0] = r_c0;
        for (int k = 0; k < NG; k++) begin
            w_term = r_c0;
            for (int j = 0; j <= k; j++) begin
                w_term = w_term & r_gp[j];
            end
            w_gc[k+1] = w_term;
            for (int j = 0; j <= k; j++) begin
                w_term = r_gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    w_term = w_term & r_gp[m];
                end
                w_gc[k+1] = w_gc[k+1] | w_term;
            end
        end
    end

    assign w_sum  = r_p ^ w_cin_bit;
    assign w_cout = w_gc[NG];
    assign w_ovf  = w_cin_bit[WIDTH-1] ^ w_cout;
    assign w_zero = ~|w_sum;

    assign w_unused = ^{r_g, w_s1_s, w_s1_c, w_s2_s, w_s2_c, w_s2_gg, w_s2_gp};

    // Stage 1 register: fills whenever it is empty or its contents move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_x        <= '0;
            r_b        <= '0;
            r_c0       <= 1'b0;
            r_g        <= '0;
            r_p        <= '0;
            r_gg       <= '0;
            r_gp       <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_x  <= x;
                r_b  <= w_b;
                r_c0 <= w_c0;
                r_g  <= x & w_b;
                r_p  <= x ^ w_b;
                r_gg <= w_s1_gg;
                r_gp <= w_s1_gp;
            end
        end
    end

    // Output register: results only change on a load carrying a valid beat, so stalls hold them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= w_zero;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed vector table, backpressure,
// mid-flight reset and a random valid/ready stream, all checked through a scoreboard queue.
module tb_pipelined_cla_adder;
    import cla_pkg::*;

    localparam int W = 16;
    localparam int G = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic         sub;
        res_t         exp;
    } vec_t;

    typedef struct {
        res_t exp;
        int   cyc;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    sb_t  sbq[$];
    res_t cur_exp;
    res_t held;
    bit   held_ok = 1'b0;
    bit   chk_lat = 1'b0;
    bit   rnd_done = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    vec_t vecs[10];

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] bb,
                                   input logic ci, input logic s);
        logic [W-1:0] eb;
        logic [W:0]   t;
        res_t         r;
        eb     = s ? ~bb : bb;
        t      = {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] == eb[W-1]) && (t[W-1] != a[W-1]);
        r.zero = (t[W-1:0] == '0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one beat at posedge+1 and hold it until it is accepted.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] bb,
                        input logic ci, input logic s, input res_t e);
        x = a; y = bb; cin = ci; sub = s; cur_exp = e; in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout in_ready stuck low, actual=0 required=1");
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && sbq.size() > 0; n++) @(negedge clk);
        check("drain_empty", 64'(sbq.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: pushes on input transfer, pops on output transfer, checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !out_ready) begin
                if (held_ok) check("stall_hold", 64'({sum, cout, ovf, zero}), 64'(held));
                held    <= {sum, cout, ovf, zero};
                held_ok <= 1'b1;
            end else begin
                held_ok <= 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_beat", 64'(sbq.size()), 64'd1);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    check("result", 64'({sum, cout, ovf, zero}), 64'(e.exp));
                    if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
            if (in_valid && in_ready) sbq.push_back('{exp: cur_exp, cyc: cyc});
        end else begin
            held_ok <= 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, MODE_ADD, '{16'h0000, 1'b1, 1'b0, 1'b1}};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, MODE_ADD, '{16'h8000, 1'b0, 1'b1, 1'b0}};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, MODE_SUB, '{16'h7FFF, 1'b1, 1'b1, 1'b0}};
        vecs[3] = '{16'h0FFF, 16'hF000, 1'b1, MODE_ADD, '{16'h0000, 1'b1, 1'b0, 1'b1}};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, MODE_ADD, '{16'h5555, 1'b0, 1'b0, 1'b0}};
        vecs[5] = '{16'h0005, 16'h0005, 1'b0, MODE_SUB, '{16'h0000, 1'b1, 1'b0, 1'b1}};
        vecs[6] = '{16'h0003, 16'h0005, 1'b0, MODE_SUB, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{16'h0010, 16'h0001, 1'b1, MODE_SUB, '{16'h000F, 1'b1, 1'b0, 1'b0}};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, MODE_ADD, '{16'h0000, 1'b1, 1'b1, 1'b1}};
        vecs[9] = '{16'h00FF, 16'h0001, 1'b1, MODE_ADD, '{16'h0101, 1'b0, 1'b0, 1'b0}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({sum, cout, ovf, zero}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed table, back-to-back with the sink always ready
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        for (int i = 0; i < 10; i++) send(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, vecs[i].exp);
        in_valid = 1'b0;
        drain();
        chk_lat = 1'b0;

        // Backpressure: two beats fill the pipe, then in_ready must stay low until the sink frees
        out_ready = 1'b0;
        send(16'h0001, 16'h0010, 1'b0, MODE_ADD, '{16'h0011, 1'b0, 1'b0, 1'b0});
        send(16'h0002, 16'h0010, 1'b0, MODE_ADD, '{16'h0012, 1'b0, 1'b0, 1'b0});
        fork
            begin
                send(16'h0003, 16'h0010, 1'b0, MODE_ADD, '{16'h0013, 1'b0, 1'b0, 1'b0});
                send(16'h0004, 16'h0010, 1'b0, MODE_ADD, '{16'h0014, 1'b0, 1'b0, 1'b0});
                in_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_hold_sum", 64'(sum), 64'h0011);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        send(16'h1111, 16'h2222, 1'b0, MODE_ADD, model(16'h1111, 16'h2222, 1'b0, MODE_ADD));
        send(16'h3333, 16'h1111, 1'b0, MODE_SUB, model(16'h3333, 16'h1111, 1'b0, MODE_SUB));
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("no_stale_beat", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        chk_lat = 1'b1;
        send(16'h00AA, 16'h0055, 1'b1, MODE_ADD, '{16'h0100, 1'b0, 1'b0, 1'b0});
        in_valid = 1'b0;
        drain();
        chk_lat = 1'b0;

        // Random mixed ADD/SUB stream with random gaps and random sink stalls
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    logic         rc;
                    logic         rs;
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send(ra, rb, rc, rs, model(ra, rb, rc, rs));
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised carry-lookahead adder/subtractor built from GROUP-bit lookahead groups joined by a second-level group-carry lookahead.
- Registered in two pipeline stages with a valid/ready handshake on both sides.
- Produces sum, carry-out, signed overflow and zero flags.
- Serves as the datapath arithmetic primitive behind accumulators and ALU slices that need more width and throughput than a flat ripple or single-level lookahead adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP, minimum GROUP.
- GROUP, 4, bits per first-level lookahead group; NG = WIDTH/GROUP groups.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- cin  in  1  carry-in; used in ADD mode only.
- sub  in  1  0 = ADD (x+y+cin), 1 = SUB (x+~y+1; cin ignored).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result bits.
- cout  out  1  carry out of the MSB (in SUB mode, 1 = no borrow).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid = 0, out_valid = 0; all stage registers, sum, cout, ovf and zero = 0. in_ready = 1 one cycle after deassertion. Reset mid-flight discards in-flight beats with no partial output.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 (registered on input transfer):
  - Effective operand b = sub ? ~y : y; effective c0 = sub ? 1 : cin.
  - Per-bit g = x & b and p = x ^ b.
  - Per-group G/P via lookahead, and in-group carries relative to a zero group carry-in.
  - Stage 1 registers x, b, c0, per-bit g/p and per-group G/P.
- Stage 2:
  - Group carries: C[0] = c0, C[k+1] = G[k] | P[k]&C[k], computed by a flat lookahead over NG groups (no ripple chain).
  - In-group carries recomputed with the true group carry-in.
  - sum = p ^ carries; cout = C[NG]; ovf and zero derived from these.
  - All results registered into the output register.
- Latency: 2 cycles from input transfer to out_valid, with no stalls. Throughput: 1 beat/cycle.
- Backpressure uses a standard stall pipeline with no skid buffer:
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 advances under the same condition.
  - in_ready = !s1_valid || (!out_valid || out_ready).
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- While out_valid && !out_ready, sum, cout, ovf and zero are held stable.
- Beats are never dropped or duplicated, and order is preserved.
- Simultaneous input and output transfer in the same cycle with a full pipe: both occur and the pipe stays full.
- The mode bit is sampled per beat, so mixed ADD/SUB streams are legal back-to-back.
- All arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Package cla_pkg holds:
  - The default WIDTH and GROUP localparams.
  - Mode constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
  - A function computing NG with a compile-time check that WIDTH % GROUP == 0.
- Sub-module cla_group (GROUP-bit):
  - Inputs a, b, ci. Outputs s, per-bit carries, group G and group P.
  - Purely combinational; instantiated NG times in each stage.

Test Plan:
- ADD wrap (WIDTH=16): x=0xFFFF, y=0x0001, cin=0 -> after 2 cycles sum=0x0000, cout=1, ovf=0, zero=1.
- Signed overflow: ADD x=0x7FFF, y=0x0001 -> sum=0x8000, cout=0, ovf=1. SUB x=0x8000, y=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Full group-carry propagation: ADD x=0x0FFF, y=0xF000, cin=1 -> sum=0x0000, cout=1, zero=1. This exercises all-P groups plus carry-in.
- Backpressure: stream 4 beats (x=1..4, y=0x10, ADD) with out_ready held low for cycles 2-5 -> in_ready drops after 2 beats are held. Results 0x11..0x14 then appear in order with no loss, duplication, or change while stalled.
- Reset mid-operation: 2 beats in flight, rst_n pulsed low -> out_valid=0 and sum=0 immediately. No stale beat emerges after release, and the next beat has latency 2.
- Random regression: mixed ADD/SUB with random valid/ready over 10k beats; compare against a reference model of (x + (sub?~y:y) + (sub?1:cin)) mod 2^WIDTH and the derived flags. Repeat with WIDTH=32/GROUP=8 and WIDTH=8/GROUP=2.
